pc_unit: RTL and testbench

- Parameterised program-counter and control-flow resolution block for the single-cycle RISC-V core.
- Owns the PC register and resolves conditional branches, JAL and JALR internally from operand data.
- Detects misaligned control-flow targets and redirects them to a trap vector.
- Holds a small return-address stack (RAS) and branch statistics counters for prediction and performance studies.

---
 rtl/pc_unit.sv | 170 +++++++++++++++++
 tb/tb_pc_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with in-house branch/JAL/JALR resolution, misaligned-target trap,
// a circular return-address stack and retired-branch statistics counters.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int              IALIGN       = 4,
    parameter int              RAS_DEPTH    = 4,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch,
    input  logic [2:0]       branch_type,
    input  logic             jump,
    input  logic             jump_reg,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [XLEN-1:0]  next_pc,
    output logic             taken,
    output logic             misalign_exc,
    output logic [XLEN-1:0]  ras_top,
    output logic             ras_valid,
    output logic             ras_hit,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int            PW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(RAS_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             misalign_exc_q, misalign_exc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [XLEN-1:0]  stack_q [RAS_DEPTH];
    logic [XLEN-1:0]  stack_d [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW:0]      cnt_q, cnt_d;

    logic             cond;
    logic [XLEN-1:0]  br_tgt;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  jalr_tgt;
    logic [XLEN-1:0]  redir_tgt;
    logic             taken_c;
    logic             misalign_c;
    logic             link_rd;
    logic             link_rs1;
    logic             push_req;
    logic             pop_req;
    logic             ras_upd;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign br_tgt   = pc_q + imm;
    assign jalr_sum = rs1_data + imm;
    assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};

    always_comb begin
        cond = 1'b0;
        case (branch_type)
            3'b000:  cond = (rs1_data == rs2_data);
            3'b001:  cond = (rs1_data != rs2_data);
            3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond = (rs1_data <  rs2_data);
            3'b111:  cond = (rs1_data >= rs2_data);
            default: cond = 1'b0;
        endcase
    end

    // JALR outranks JAL, which outranks a taken branch; the fall-through path is never checked.
    always_comb begin
        taken_c    = jump_reg | jump | (branch & cond);
        redir_tgt  = jump_reg ? jalr_tgt : br_tgt;
        misalign_c = 1'b0;
        if (taken_c) begin
            misalign_c = (IALIGN == 2) ? redir_tgt[0] : (redir_tgt[1:0] != 2'b00);
        end
        if (!taken_c) begin
            next_pc = pc_plus4;
        end else if (misalign_c) begin
            next_pc = TRAP_VECTOR;
        end else begin
            next_pc = redir_tgt;
        end
    end

    assign taken    = taken_c;
    assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
    assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign push_req = (jump | jump_reg) & link_rd;
    assign pop_req  = jump_reg & link_rs1 & ~(link_rd & (rd == rs1));
    assign ras_upd  = ~stall & ~misalign_c;

    assign ras_valid = (cnt_q != '0);
    assign ras_top   = ras_valid ? stack_q[ptr_q] : '0;
    assign ras_hit   = pop_req & ras_valid & (stack_q[ptr_q] == jalr_tgt);

    // Pop is applied before push so a link-to-link JALR replaces the top in place.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        stack_d = stack_q;
        if (ras_upd) begin
            if (pop_req && (cnt_q != '0)) begin
                ptr_d = ptr_q - PW'(1);
                cnt_d = cnt_q - (PW+1)'(1);
            end
            if (push_req) begin
                ptr_d          = ptr_d + PW'(1);
                stack_d[ptr_d] = pc_plus4;
                if (cnt_d != DEPTH_C) begin
                    cnt_d = cnt_d + (PW+1)'(1);
                end
            end
        end
    end

    always_comb begin
        pc_d           = pc_q;
        misalign_exc_d = misalign_exc_q;
        branch_cnt_d   = branch_cnt_q;
        taken_cnt_d    = taken_cnt_q;
        if (!stall) begin
            pc_d           = next_pc;
            misalign_exc_d = misalign_c;
            if (branch) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
            if (taken_c) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= RESET_VECTOR;
            misalign_exc_q <= 1'b0;
            branch_cnt_q   <= '0;
            taken_cnt_q    <= '0;
            ptr_q          <= '0;
            cnt_q          <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q           <= pc_d;
            misalign_exc_q <= misalign_exc_d;
            branch_cnt_q   <= branch_cnt_d;
            taken_cnt_q    <= taken_cnt_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            stack_q        <= stack_d;
        end
    end

    assign pc           = pc_q;
    assign misalign_exc = misalign_exc_q;
    assign branch_cnt   = branch_cnt_q;
    assign taken_cnt    = taken_cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized control-flow traffic.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [2:0]  branch_type;
    logic        jump;
    logic        jump_reg;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        taken;
    logic        misalign_exc;
    logic [31:0] ras_top;
    logic        ras_valid;
    logic        ras_hit;
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;

    pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branch_type(branch_type),
        .jump(jump), .jump_reg(jump_reg), .rd(rd), .rs1(rs1), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .pc(pc), .pc_plus4(pc_plus4), .next_pc(next_pc),
        .taken(taken), .misalign_exc(misalign_exc), .ras_top(ras_top), .ras_valid(ras_valid),
        .ras_hit(ras_hit), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc, m_bcnt, m_tcnt;
    logic        m_exc;
    logic [31:0] ras[$];
    logic        s_hit, s_valid;
    logic [31:0] s_next;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0;
        m_bcnt = 0;
        m_tcnt = 0;
        m_exc  = 1'b0;
        ras.delete();
    endtask

    task automatic set_nop();
        stall = 0; branch = 0; branch_type = 3'b010; jump = 0; jump_reg = 0;
        rd = 0; rs1 = 0; rs1_data = 0; rs2_data = 0; imm = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic step();
        logic        c, e_taken, e_mis, e_push, e_pop, e_valid, e_hit;
        logic [31:0] tgt, jt, top, e_next, old_pc;
        @(negedge clk);
        case (branch_type)
            3'd0:    c = (rs1_data == rs2_data);
            3'd1:    c = (rs1_data != rs2_data);
            3'd4:    c = ($signed(rs1_data) <  $signed(rs2_data));
            3'd5:    c = ($signed(rs1_data) >= $signed(rs2_data));
            3'd6:    c = (rs1_data <  rs2_data);
            3'd7:    c = (rs1_data >= rs2_data);
            default: c = 1'b0;
        endcase
        jt      = (rs1_data + imm) & ~32'h1;
        e_taken = jump_reg || jump || (branch && c);
        tgt     = jump_reg ? jt : m_pc + imm;
        e_mis   = e_taken && (tgt[1:0] != 2'b00);
        e_next  = !e_taken ? m_pc + 32'd4 : (e_mis ? 32'h100 : tgt);
        e_push  = (jump || jump_reg) && is_link(rd);
        e_pop   = jump_reg && is_link(rs1) && !(is_link(rd) && rd == rs1);
        e_valid = ras.size() > 0;
        top     = e_valid ? ras[$] : 32'h0;
        e_hit   = e_pop && e_valid && (top == jt);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("next_pc", next_pc, e_next);
        chk("taken", taken, e_taken);
        chk("misalign_exc", misalign_exc, m_exc);
        chk("ras_valid", ras_valid, e_valid);
        chk("ras_top", ras_top, top);
        chk("ras_hit", ras_hit, e_hit);
        chk("branch_cnt", branch_cnt, m_bcnt);
        chk("taken_cnt", taken_cnt, m_tcnt);
        s_hit   = ras_hit;
        s_valid = ras_valid;
        s_next  = next_pc;
        @(posedge clk);
        if (!stall && !rst) begin
            old_pc = m_pc;
            m_pc   = e_next;
            if (!e_mis) begin
                if (e_pop && ras.size() > 0) void'(ras.pop_back());
                if (e_push) begin
                    ras.push_back(old_pc + 32'd4);
                    if (ras.size() > 4) void'(ras.pop_front());
                end
            end
            if (branch)  m_bcnt++;
            if (e_taken) m_tcnt++;
            m_exc = e_mis;
        end
        #1;
    endtask

    task automatic quick_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    logic [31:0] p0, t0;

    initial begin
        set_nop();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_pc", pc, 32'h0);
        chk("reset_ras_valid", ras_valid, 32'h0);
        chk("reset_ras_top", ras_top, 32'h0);

        repeat (3) step();
        chk("seq_pc_c", pc, 32'hC);
        chk("seq_bcnt", branch_cnt, 32'h0);
        step();
        chk("seq_pc_10", pc, 32'h10);

        branch = 1; branch_type = 3'b100; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'h1; imm = 32'h20;
        step();
        chk("blt_next", s_next, 32'h30);
        chk("blt_pc", pc, 32'h30);
        branch_type = 3'b110;
        step();
        chk("bltu_next", s_next, 32'h34);
        chk("br_bcnt", branch_cnt, 32'd2);
        chk("br_tcnt", taken_cnt, 32'd1);

        set_nop();
        repeat (3) step();
        jump = 1; rd = 5'd1; imm = 32'h100;
        step();
        chk("jal_pc", pc, 32'h140);
        chk("jal_ras_top", ras_top, 32'h44);
        set_nop();
        jump_reg = 1; rd = 5'd0; rs1 = 5'd1; rs1_data = 32'h44;
        step();
        chk("ret_hit", s_hit, 32'h1);
        chk("ret_pc", pc, 32'h44);
        chk("ret_valid", ras_valid, 32'h0);

        quick_reset();
        set_nop();
        jump = 1; rd = 5'd1; imm = 32'h100;
        repeat (5) step();
        chk("nest_pc", pc, 32'h500);
        chk("nest_top", ras_top, 32'h404);
        set_nop();
        jump_reg = 1; rd = 5'd0; rs1 = 5'd1;
        for (int k = 0; k < 4; k++) begin
            rs1_data = 32'h404 - 32'h100 * k;
            step();
            chk("nest_ret_hit", s_hit, 32'h1);
        end
        rs1_data = 32'h4;
        step();
        chk("nest_empty_valid", s_valid, 32'h0);
        chk("nest_empty_hit", s_hit, 32'h0);

        set_nop();
        jump = 1; rd = 5'd1; imm = 32'h8;
        step();
        chk("pre_mis_top", ras_top, 32'h8);
        set_nop();
        jump_reg = 1; rd = 5'd1; rs1 = 5'd0; rs1_data = 32'h102;
        step();
        chk("mis_next", s_next, 32'h100);
        chk("mis_exc_hi", misalign_exc, 32'h1);
        chk("mis_ras_top", ras_top, 32'h8);
        set_nop();
        step();
        chk("mis_exc_lo", misalign_exc, 32'h0);
        chk("mis_after_pc", pc, 32'h104);

        p0 = m_pc; t0 = m_tcnt;
        set_nop();
        stall = 1; branch = 1; branch_type = 3'b000; rs1_data = 5; rs2_data = 5; imm = 32'h40;
        repeat (3) step();
        chk("stall_pc", pc, p0);
        chk("stall_tcnt", taken_cnt, t0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_bcnt", branch_cnt, 32'h0);
        model_reset();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 600; n++) begin
            int kind;
            kind     = int'($urandom_range(0, 7));
            stall    = ($urandom_range(0, 9) < 2);
            branch   = (kind == 3 || kind == 4) || (kind == 7 && $urandom_range(0, 1) == 1);
            jump     = (kind == 5) || (kind == 7 && $urandom_range(0, 1) == 1);
            jump_reg = (kind == 6) || (kind == 7 && $urandom_range(0, 1) == 1);
            branch_type = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: rd = 5'd1;
                1: rd = 5'd5;
                2: rd = 5'd0;
                default: rd = 5'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 3))
                0: rs1 = 5'd1;
                1: rs1 = 5'd5;
                2: rs1 = 5'd0;
                default: rs1 = 5'($urandom_range(0, 31));
            endcase
            imm = ($urandom_range(0, 9) == 0) ? $urandom : (32'($urandom_range(0, 255)) * 4 - 32'd512);
            if (jump_reg && ras.size() > 0 && $urandom_range(0, 1) == 1) begin
                rs1_data = ras[$] - imm;
            end else if ($urandom_range(0, 7) == 0) begin
                rs1_data = $urandom;
            end else begin
                rs1_data = $urandom & ~32'h3;
            end
            rs2_data = ($urandom_range(0, 1) == 1) ? rs1_data : $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
